// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between the
// instruction-fetch stage and the load/store stage. Data normally wins a
// contended grant; after STARVE_MAX consecutive contended data grants fetch
// is forced through. A per-access watchdog aborts accesses the memory never
// answers and raises a sticky error flag.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,    // 1..15
    parameter int unsigned TIMEOUT    = 255   // 1..65535
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // data requester
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    // memory side
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    // hazard unit / status
    output logic        stall_if,
    output logic        stall_mem,
    output logic        timeout_err
);

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    // Counter is cleared on grant, so the abort lands TIMEOUT cycles after it.
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT}    state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t      state_reg;
    owner_t      owner_reg;
    logic        we_reg;
    logic [3:0]  starve_cnt_reg;
    logic [15:0] to_cnt_reg;
    logic        timeout_err_reg;

    logic in_wait;
    logic abort;
    logic issue_win;
    logic pick_data;
    logic grant;
    logic own_fetch;
    logic own_data;

    assign in_wait   = (state_reg == ST_WAIT);
    assign abort     = in_wait & ~mem_rvalid & (to_cnt_reg == TO_LAST);
    // New access may issue when idle or in the same cycle the current one
    // completes; nothing issues while reset is asserted.
    assign issue_win = rst_n & (~in_wait | mem_rvalid);

    // Data wins contention unless fetch has been starved long enough.
    assign pick_data = dm_req & (~if_req | (starve_cnt_reg != STARVE_LIM));

    assign mem_req = issue_win & (if_req | dm_req);
    assign grant   = mem_req & mem_ready;
    assign if_gnt  = grant & ~pick_data;
    assign dm_gnt  = grant & pick_data;

    // Route the selected requester onto the memory request fields.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (mem_req) begin
            if (pick_data) begin
                mem_we    = dm_we;
                mem_be    = dm_be;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end else begin
                mem_be    = 4'hF;
                mem_addr  = if_addr;
            end
        end
    end

    assign own_fetch = in_wait & (owner_reg == OWN_FETCH);
    assign own_data  = in_wait & (owner_reg == OWN_DATA);

    // Completion (real or aborted) goes only to the owner; aborts return 0.
    assign if_rvalid = own_fetch & (mem_rvalid | abort);
    assign dm_rvalid = own_data  & (mem_rvalid | abort);
    assign if_rdata  = (own_fetch & mem_rvalid) ? mem_rdata : 32'h0;
    assign dm_rdata  = (own_data & mem_rvalid & ~we_reg) ? mem_rdata : 32'h0;

    assign stall_if    = rst_n & if_req & ~if_rvalid;
    assign stall_mem   = rst_n & dm_req & ~dm_rvalid;
    assign timeout_err = timeout_err_reg;

    // Access sequencer, ownership, watchdog and starvation bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= OWN_FETCH;
            we_reg          <= 1'b0;
            starve_cnt_reg  <= 4'h0;
            to_cnt_reg      <= 16'h0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (grant) begin
                state_reg  <= ST_WAIT;
                owner_reg  <= pick_data ? OWN_DATA : OWN_FETCH;
                we_reg     <= pick_data & dm_we;
                to_cnt_reg <= 16'h0;
            end else if (in_wait & (mem_rvalid | abort)) begin
                state_reg  <= ST_IDLE;
            end else if (in_wait) begin
                to_cnt_reg <= to_cnt_reg + 16'h1;
            end

            if (abort) begin
                timeout_err_reg <= 1'b1;
            end

            if (!if_req) begin
                starve_cnt_reg <= 4'h0;
            end else if (grant) begin
                if (!pick_data) begin
                    starve_cnt_reg <= 4'h0;
                end else if (starve_cnt_reg != STARVE_LIM) begin
                    starve_cnt_reg <= starve_cnt_reg + 4'h1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors plus
// hand-written timeout and reset sequences. Inputs change on the falling
// edge and outputs are sampled 2 ns later, well clear of the rising edge.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_ready;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        dm_gnt;
        logic        dm_rvalid;
        logic [31:0] dm_rdata;
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        stall_if;
        logic        stall_mem;
        logic        timeout_err;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    mem_port_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_be       (dm_be),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_gnt      (dm_gnt),
        .dm_rvalid   (dm_rvalid),
        .dm_rdata    (dm_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk_in(int ir, int ia, int dr, int dwe, int dbe, int da,
                                  int dwd, int rdy, int rv, int rd);
        in_t r;
        r.if_req     = ir[0];
        r.if_addr    = ia;
        r.dm_req     = dr[0];
        r.dm_we      = dwe[0];
        r.dm_be      = dbe[3:0];
        r.dm_addr    = da;
        r.dm_wdata   = dwd;
        r.mem_ready  = rdy[0];
        r.mem_rvalid = rv[0];
        r.mem_rdata  = rd;
        return r;
    endfunction

    function automatic out_t mk_out(int ig, int irv, int ird, int dg, int drv, int drd,
                                    int mrq, int mwe, int mbe, int mad, int mwd,
                                    int sif, int smem, int terr);
        out_t r;
        r.if_gnt      = ig[0];
        r.if_rvalid   = irv[0];
        r.if_rdata    = ird;
        r.dm_gnt      = dg[0];
        r.dm_rvalid   = drv[0];
        r.dm_rdata    = drd;
        r.mem_req     = mrq[0];
        r.mem_we      = mwe[0];
        r.mem_be      = mbe[3:0];
        r.mem_addr    = mad;
        r.mem_wdata   = mwd;
        r.stall_if    = sif[0];
        r.stall_mem   = smem[0];
        r.timeout_err = terr[0];
        return r;
    endfunction

    task automatic add(input string nm, input in_t i, input out_t e);
        vec_t v;
        v.name = nm;
        v.i    = i;
        v.e    = e;
        vecs.push_back(v);
    endtask

    // One cycle: drive inputs on the falling edge, compare 2 ns later.
    task automatic step(input string nm, input logic rst, input in_t i, input out_t e);
        out_t a;
        @(negedge clk);
        rst_n      = rst;
        if_req     = i.if_req;
        if_addr    = i.if_addr;
        dm_req     = i.dm_req;
        dm_we      = i.dm_we;
        dm_be      = i.dm_be;
        dm_addr    = i.dm_addr;
        dm_wdata   = i.dm_wdata;
        mem_ready  = i.mem_ready;
        mem_rvalid = i.mem_rvalid;
        mem_rdata  = i.mem_rdata;
        #2;
        a.if_gnt      = if_gnt;
        a.if_rvalid   = if_rvalid;
        a.if_rdata    = if_rdata;
        a.dm_gnt      = dm_gnt;
        a.dm_rvalid   = dm_rvalid;
        a.dm_rdata    = dm_rdata;
        a.mem_req     = mem_req;
        a.mem_we      = mem_we;
        a.mem_be      = mem_be;
        a.mem_addr    = mem_addr;
        a.mem_wdata   = mem_wdata;
        a.stall_if    = stall_if;
        a.stall_mem   = stall_mem;
        a.timeout_err = timeout_err;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got if{g%b v%b d%h} dm{g%b v%b d%h} mem{r%b w%b be%h a%h wd%h} st%b%b te%b, required if{g%b v%b d%h} dm{g%b v%b d%h} mem{r%b w%b be%h a%h wd%h} st%b%b te%b",
                     nm, a.if_gnt, a.if_rvalid, a.if_rdata, a.dm_gnt, a.dm_rvalid, a.dm_rdata,
                     a.mem_req, a.mem_we, a.mem_be, a.mem_addr, a.mem_wdata,
                     a.stall_if, a.stall_mem, a.timeout_err,
                     e.if_gnt, e.if_rvalid, e.if_rdata, e.dm_gnt, e.dm_rvalid, e.dm_rdata,
                     e.mem_req, e.mem_we, e.mem_be, e.mem_addr, e.mem_wdata,
                     e.stall_if, e.stall_mem, e.timeout_err);
        end else begin
            $display("ok   %s", nm);
        end
    endtask

    initial begin
        logic win_data [10];
        in_t  ci;
        out_t ce;
        logic has_prev;
        logic prev_d;
        logic reqs;
        logic wd;

        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_be      = 4'h0;
        dm_addr    = 32'h0;
        dm_wdata   = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // ---------------- vector table ----------------
        add("fetch_c0_grant",    mk_in(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
                                 mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 0, 0));
        add("fetch_c1_rvalid",   mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00500093),
                                 mk_out(0, 1, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("idle_stray_rvalid", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234),
                                 mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("store_grant",       mk_in(0, 0, 1, 1, 4'b0011, 32'h2000, 32'hDEADBEEF, 1, 0, 0),
                                 mk_out(0, 0, 0, 1, 0, 0, 1, 1, 4'b0011, 32'h2000, 32'hDEADBEEF, 0, 1, 0));
        add("store_ack_rdata0",  mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF),
                                 mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("load_grant",        mk_in(0, 0, 1, 0, 4'hF, 32'h3000, 32'h55, 1, 0, 0),
                                 mk_out(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h3000, 32'h55, 0, 1, 0));
        add("load_rsp",          mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D),
                                 mk_out(0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            add("bp_not_ready",  mk_in(0, 0, 1, 0, 4'hF, 32'h4000, 0, 0, 0, 0),
                                 mk_out(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h4000, 0, 0, 1, 0));
        end
        add("bp_ready_grant",    mk_in(0, 0, 1, 0, 4'hF, 32'h4000, 0, 1, 0, 0),
                                 mk_out(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h4000, 0, 0, 1, 0));
        add("bp_rsp",            mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11),
                                 mk_out(0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0));

        // Contention with STARVE_MAX=4: required grant order D,D,D,D,F,D,D,D,D,F,
        // memory answering every cycle so each response overlaps the next grant.
        win_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c <= 10; c++) begin
            reqs     = (c < 10);
            has_prev = (c > 0);
            prev_d   = (c > 0) ? win_data[c-1] : 1'b0;
            wd       = (c < 10) ? win_data[c] : 1'b0;
            ci = mk_in(int'(reqs), 32'h500, int'(reqs), 0, 4'hF, 32'h600, 0, 1,
                       int'(has_prev), 32'hA0000000 + c);
            ce = '0;
            ce.if_rvalid = has_prev & ~prev_d;
            ce.dm_rvalid = has_prev & prev_d;
            ce.if_rdata  = ce.if_rvalid ? ci.mem_rdata : 32'h0;
            ce.dm_rdata  = ce.dm_rvalid ? ci.mem_rdata : 32'h0;
            ce.mem_req   = reqs;
            ce.dm_gnt    = reqs & wd;
            ce.if_gnt    = reqs & ~wd;
            ce.mem_be    = reqs ? 4'hF : 4'h0;
            ce.mem_addr  = reqs ? (wd ? 32'h600 : 32'h500) : 32'h0;
            ce.stall_if  = reqs & ~ce.if_rvalid;
            ce.stall_mem = reqs & ~ce.dm_rvalid;
            add($sformatf("contend_c%0d_%s", c, !reqs ? "end" : (wd ? "D" : "F")), ci, ce);
        end

        // ---------------- reset state ----------------
        step("reset_state", 1'b0, mk_in(1, 32'h100, 1, 0, 4'hF, 32'h200, 0, 1, 1, 32'h1234),
             mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("reset_release", 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[n]) begin
            step(vecs[n].name, 1'b1, vecs[n].i, vecs[n].e);
        end

        // ---------------- timeout (TIMEOUT=8) ----------------
        step("to_grant", 1'b1, mk_in(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 32'hBAD),
             mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h700, 0, 1, 0, 0));
        for (int k = 1; k < 8; k++) begin
            step($sformatf("to_wait_%0d", k), 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBAD),
                 mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        step("to_abort_8", 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBAD),
             mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("to_err_set", 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBAD),
             mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("to_next_grant", 1'b1, mk_in(0, 0, 1, 0, 4'hF, 32'h800, 0, 1, 0, 0),
             mk_out(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h800, 0, 0, 1, 1));
        step("to_next_rsp", 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99),
             mk_out(0, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, 1));

        // ---------------- reset mid-access ----------------
        step("rst_grant", 1'b1, mk_in(1, 32'h900, 0, 0, 0, 0, 0, 1, 0, 0),
             mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h900, 0, 1, 0, 1));
        for (int k = 0; k < 2; k++) begin
            step("rst_held_outputs0", 1'b0,
                 mk_in(1, 32'h900, 1, 1, 4'hF, 32'hA00, 32'h77, 1, 1, 32'h5555),
                 mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        step("rst_stale_rvalid", 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5555),
             mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rst_after_grant", 1'b1, mk_in(1, 32'hB00, 0, 0, 0, 0, 0, 1, 0, 0),
             mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'hB00, 0, 1, 0, 0));
        step("rst_after_rsp", 1'b1, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h42),
             mk_out(0, 1, 32'h42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, single-outstanding memory between the instruction-fetch stage and the load/store (MEM) stage of the 5-stage core.
- Arbitrates between the two requesters, sequences each access through an issue/wait state machine, and routes responses back to the owner.
- Generates stall requests for the hazard unit.
- Guards against fetch starvation and against memory that never responds.

Parameters:
- STARVE_MAX, 4: consecutive contended data grants allowed before fetch is forced to win the next contended grant (range 1..15).
- TIMEOUT, 255: cycles to wait for mem_rvalid after a grant before aborting (range 1..65535).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  32  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetch data
- dm_req  in  1  data request; held stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  store byte enables
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data request accepted
- dm_rvalid  out  1  load data / store ack, one-cycle pulse
- dm_rdata  out  32  load data (0 for stores)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables (4'hF for fetch)
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory accepts request when mem_req & mem_ready
- mem_rvalid  in  1  response for the outstanding access (reads and writes)
- mem_rdata  in  32  read data
- stall_if  out  1  if_req & ~if_rvalid
- stall_mem  out  1  dm_req & ~dm_rvalid
- timeout_err  out  1  sticky: a TIMEOUT abort has occurred

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; owner, starve counter and timeout counter cleared.
  - All outputs 0, including timeout_err.
  - Any in-flight access is dropped; mem_rvalid arriving in IDLE is ignored.
- States:
  - IDLE: no access outstanding.
  - WAIT: one access outstanding; owner register holds FETCH or DATA.
- Issue window: the cycle is in IDLE, or in WAIT with mem_rvalid high (back-to-back, zero bubble).
- Requests:
  - In the issue window, mem_req = if_req | dm_req.
  - mem_* fields are driven combinationally from the selected requester.
  - A grant occurs when mem_req & mem_ready. Only the winner's gnt pulses high, for that cycle only.
  - After a grant: state goes to WAIT, owner is latched, timeout counter is cleared.
  - With no grant: IDLE holds IDLE; WAIT with mem_rvalid returns to IDLE.
- Selection:
  - Only one requester active: that requester wins.
  - Both active: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments on each data grant while if_req is high; it saturates.
  - starve_cnt clears on a fetch grant or whenever if_req is low.
- Response:
  - In WAIT, mem_rvalid drives the owner's rvalid high the same cycle (combinational).
  - rdata = mem_rdata, except dm_rdata = 0 when the owner's access was a store (latched we).
  - The non-owner's rvalid stays 0.
- Timeout:
  - In WAIT, the counter increments each cycle without mem_rvalid.
  - On reaching TIMEOUT: pulse the owner's rvalid with rdata 0, set timeout_err, return to IDLE.
  - No issue occurs in the abort cycle.
- Stalls: stall_if and stall_mem are combinational per the port definitions. Both requesters can be stalled in the same cycle.
- mem_ready low: request is held, no grant, state unchanged.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid one cycle later with rdata=0x00500093. Required: if_gnt in cycle 0; if_rvalid=1 with if_rdata=0x00500093 in cycle 1; stall_if=1 in cycle 0, 0 in cycle 1.
- Contention, STARVE_MAX=4: both requests held, memory responds every cycle. Required grant order is D,D,D,D,F,D,D,D,D,F, with no idle cycle between accesses.
- Store: dm_we=1, dm_be=4'b0011, dm_addr=0x2000, dm_wdata=0xDEADBEEF. Required: mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; dm_rvalid on ack with dm_rdata=0.
- Timeout, TIMEOUT=8: fetch granted, mem_rvalid never asserted. Required: if_rvalid=1 with if_rdata=0 exactly 8 cycles after grant; timeout_err=1 and stays 1; next request issues normally.
- Reset mid-access: assert rst_n=0 while in WAIT, release, then pulse mem_rvalid. Required: all outputs 0 during reset; the stale rvalid produces no if_rvalid/dm_rvalid.
- Backpressure: mem_ready=0 for 3 cycles with dm_req=1. Required: mem_req=1 throughout, no dm_gnt, stall_mem=1; grant in the cycle mem_ready rises.
